// File: rtl/pkt_fifo_param.sv
// Parametrised single-clock packet FIFO with first-word-fall-through output, occupancy count
// and programmable almost-full/almost-empty flags. Define FIFO_ERR_EN for sticky ovf/udf flags.
module pkt_fifo_param #(
   parameter int DW       = 10,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 2,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] pkti,
   input  logic          we,
   output logic          full,
   output logic          almost_full,
   input  logic          re,
   output logic [DW-1:0] pkto,
   output logic          empty,
   output logic          almost_empty,
   output logic [AW:0]   count
`ifdef FIFO_ERR_EN
   ,
   output logic          ovf,
   output logic          udf,
   input  logic          err_clr
`endif
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   head;
   logic [AW:0]   tail;
   logic          wr_ok;
   logic          rd_ok;

   // Extra pointer MSB makes head - tail the exact occupancy, DEPTH included.
   assign count        = head - tail;
   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   assign wr_ok = we & ~full;
   assign rd_ok = re & ~empty;

   assign pkto = empty ? '0 : mem[tail[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (wr_ok) head <= head + 1'b1;
         if (rd_ok) tail <= tail + 1'b1;
      end
   end

   // Storage is deliberately not reset; stale entries are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (wr_ok && !rst) mem[head[AW-1:0]] <= pkti;
   end

`ifdef FIFO_ERR_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         if (we && full)   ovf <= 1'b1;
         else if (err_clr) ovf <= 1'b0;
         if (re && empty)  udf <= 1'b1;
         else if (err_clr) udf <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_pkt_fifo_param.sv
// Self-checking bench for pkt_fifo_param: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_pkt_fifo_param;

   localparam int DW    = 10;
   localparam int DEPTH = 16;
   localparam int AF    = 12;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          we = 1'b0;
   logic          re = 1'b0;
   logic          err_clr = 1'b0;
   logic [DW-1:0] pkti = '0;
   logic          full, almost_full, empty, almost_empty;
   logic [DW-1:0] pkto;
   logic [4:0]    count;
`ifdef FIFO_ERR_EN
   logic          ovf, udf;
`endif

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] q[$];
   bit            m_ovf = 1'b0;
   bit            m_udf = 1'b0;

   always #5 clk = ~clk;

   pkt_fifo_param #(.DW(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
      .clk(clk), .rst(rst), .pkti(pkti), .we(we), .full(full), .almost_full(almost_full),
      .re(re), .pkto(pkto), .empty(empty), .almost_empty(almost_empty), .count(count)
`ifdef FIFO_ERR_EN
      , .ovf(ovf), .udf(udf), .err_clr(err_clr)
`endif
   );

   // Advance one clock edge and apply the same edge to the reference model.
   task automatic tick();
      bit full_m, empty_m;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         full_m  = (q.size() == DEPTH);
         empty_m = (q.size() == 0);
         if (we && full_m) m_ovf = 1'b1;
         else if (err_clr) m_ovf = 1'b0;
         if (re && empty_m) m_udf = 1'b1;
         else if (err_clr) m_udf = 1'b0;
         if (re && !empty_m) void'(q.pop_front());
         if (we && !full_m) q.push_back(pkti);
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; we = 1'b0; re = 1'b0; err_clr = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; we = 1'b1; re = 1'b1; pkti = 10'h2A5;
      tick();
      tick();
      rst = 1'b0; we = 1'b0; re = 1'b0;
      #1;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if (pkto !== '0) begin errors++; $display("FAIL reset_pkto got %h exp 000", pkto); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
      checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b exp 1", almost_empty); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", almost_full); end
   endtask

   task automatic test_fill_drain();
      do_reset();
      for (int i = 1; i <= DEPTH; i++) begin
         we = 1'b1; pkti = DW'(i);
         tick();
         checks++; if (count !== 5'(i)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i); end
         checks++; if (almost_full !== (i >= AF)) begin errors++; $display("FAIL fill_afull[%0d] got %b exp %b", i, almost_full, i >= AF); end
         checks++; if (full !== (i == DEPTH)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, i == DEPTH); end
      end
      pkti = 10'h3FF;
      tick();
      we = 1'b0;
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL overfill_count got %0d exp 16", count); end
      checks++; if (pkto !== 10'h001) begin errors++; $display("FAIL overfill_head got %h exp 001", pkto); end
      for (int i = 1; i <= DEPTH; i++) begin
         checks++; if (pkto !== DW'(i)) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, pkto, DW'(i)); end
         re = 1'b1;
         tick();
      end
      re = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
      checks++; if (pkto !== '0) begin errors++; $display("FAIL drain_pkto got %h exp 000", pkto); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] nxt = 10'h100;
      do_reset();
      we = 1'b1;
      for (int i = 0; i < 8; i++) begin pkti = nxt; nxt++; tick(); end
      re = 1'b1;
      for (int i = 0; i < 40; i++) begin
         pkti = nxt; nxt++;
         checks++; if (pkto !== q[0]) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, pkto, q[0]); end
         tick();
         checks++; if (count !== 5'd8) begin errors++; $display("FAIL b2b_count[%0d] got %0d exp 8", i, count); end
      end
      we = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++; if (pkto !== DW'(10'h100 + 40 + i)) begin errors++; $display("FAIL b2b_tail[%0d] got %h exp %h", i, pkto, DW'(10'h100 + 40 + i)); end
         tick();
      end
      re = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b exp 1", empty); end
   endtask

   task automatic test_full_rw();
      logic [DW-1:0] head;
      do_reset();
      we = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin pkti = DW'($urandom_range(0, 10'h1FF)); tick(); end
      head = q[0];
      re = 1'b1; pkti = 10'h2AA;
      checks++; if (pkto !== head) begin errors++; $display("FAIL fullrw_head got %h exp %h", pkto, head); end
      tick();
      we = 1'b0;
      checks++; if (count !== 5'd15) begin errors++; $display("FAIL fullrw_count got %0d exp 15", count); end
      for (int i = 0; i < 15; i++) begin
         checks++; if (pkto === 10'h2AA) begin errors++; $display("FAIL fullrw_stored[%0d] got %h exp not 2aa", i, pkto); end
         tick();
      end
      re = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fullrw_empty got %b exp 1", empty); end
   endtask

   task automatic test_empty_rw();
      do_reset();
      we = 1'b1; re = 1'b1; pkti = 10'h155;
      tick();
      we = 1'b0; re = 1'b0;
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL emptyrw_count got %0d exp 1", count); end
      checks++; if (pkto !== 10'h155) begin errors++; $display("FAIL emptyrw_pkto got %h exp 155", pkto); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL emptyrw_empty got %b exp 0", empty); end
   endtask

   task automatic test_random();
      logic [DW-1:0] ep;
      int sz;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         we = ($urandom_range(0, 99) < ((i / 100) % 2 ? 35 : 65));
         re = ($urandom_range(0, 99) < ((i / 100) % 2 ? 65 : 35));
         err_clr = ($urandom_range(0, 15) == 0);
         pkti = DW'($urandom);
         tick();
         sz = q.size();
         ep = (sz != 0) ? q[0] : '0;
         checks++; if (count !== 5'(sz)) begin errors++; $display("FAIL rnd_count[%0d] got %0d exp %0d", i, count, sz); end
         checks++; if (pkto !== ep) begin errors++; $display("FAIL rnd_pkto[%0d] got %h exp %h", i, pkto, ep); end
         checks++; if (empty !== (sz == 0)) begin errors++; $display("FAIL rnd_empty[%0d] got %b exp %b", i, empty, sz == 0); end
         checks++; if (full !== (sz == DEPTH)) begin errors++; $display("FAIL rnd_full[%0d] got %b exp %b", i, full, sz == DEPTH); end
         checks++; if (almost_full !== (sz >= AF)) begin errors++; $display("FAIL rnd_afull[%0d] got %b exp %b", i, almost_full, sz >= AF); end
         checks++; if (almost_empty !== (sz <= AE)) begin errors++; $display("FAIL rnd_aempty[%0d] got %b exp %b", i, almost_empty, sz <= AE); end
`ifdef FIFO_ERR_EN
         checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d] got %b exp %b", i, ovf, m_ovf); end
         checks++; if (udf !== m_udf) begin errors++; $display("FAIL rnd_udf[%0d] got %b exp %b", i, udf, m_udf); end
`endif
      end
      we = 1'b0; re = 1'b0; err_clr = 1'b0;
   endtask

`ifdef FIFO_ERR_EN
   task automatic test_err();
      do_reset();
      re = 1'b1;
      tick();
      re = 1'b0;
      tick();
      checks++; if (udf !== 1'b1) begin errors++; $display("FAIL err_udf_sticky got %b exp 1", udf); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL err_ovf_quiet got %b exp 0", ovf); end
      we = 1'b1;
      for (int i = 0; i <= DEPTH; i++) begin pkti = DW'(i); tick(); end
      we = 1'b0;
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL err_ovf_set got %b exp 1", ovf); end
      err_clr = 1'b1; we = 1'b1;
      tick();
      we = 1'b0;
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL err_set_wins got %b exp 1", ovf); end
      checks++; if (udf !== 1'b0) begin errors++; $display("FAIL err_udf_clr got %b exp 0", udf); end
      tick();
      err_clr = 1'b0;
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL err_ovf_clr got %b exp 0", ovf); end
   endtask
`endif

   task automatic test_reset_mid();
      do_reset();
      we = 1'b1;
      for (int i = 0; i < 5; i++) begin pkti = DW'(10'h200 + i); tick(); end
      re = 1'b1; err_clr = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0; we = 1'b0; re = 1'b0;
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got %b exp 1", empty); end
      checks++; if (pkto !== '0) begin errors++; $display("FAIL rstmid_pkto got %h exp 000", pkto); end
      checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL rstmid_aempty got %b exp 1", almost_empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL rstmid_full got %b exp 0", full); end
`ifdef FIFO_ERR_EN
      checks++; if ((ovf | udf) !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b%b exp 00", ovf, udf); end
`endif
      we = 1'b1; pkti = 10'h0AB;
      tick();
      we = 1'b0;
      checks++; if (pkto !== 10'h0AB || count !== 5'd1) begin errors++; $display("FAIL rstmid_after got %h/%0d exp 0ab/1", pkto, count); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_back_to_back();
      test_full_rw();
      test_empty_rw();
      test_random();
`ifdef FIFO_ERR_EN
      test_err();
`endif
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
